// File: rtl/dpll_pkg.sv
// rtl/dpll_pkg.sv - shared types, defaults and sizing helper for the DPSK bit-sync DPLL
package dpll_pkg;

  localparam int DIV_N_DEF  = 16;
  localparam int DIV_W_DEF  = 4;
  localparam int K_FILT_DEF = 4;

  typedef enum logic [1:0] {
    PH_NONE = 2'd0,
    PH_LEAD = 2'd1,
    PH_LAG  = 2'd2
  } phase_e;

  // Signed walk counter must hold +/-K_FILT without overflow.
  function automatic int walk_width(input int k_filt);
    return $clog2(k_filt) + 2;
  endfunction

endpackage

// File: rtl/dpll_loop_filter.sv
// rtl/dpll_loop_filter.sv - random-walk loop filter; one-cycle add/del requests at +/-K_FILT
module dpll_loop_filter
  import dpll_pkg::*;
#(
  parameter int K_FILT = K_FILT_DEF
) (
  input  logic   clk32_i,
  input  logic   rst_n_i,
  input  phase_e phase_i,
  input  logic   phase_vld_i,
  output logic   add_req,
  output logic   del_req
);

  localparam int WW = walk_width(K_FILT);
  localparam logic signed [WW-1:0] K_POS = WW'(K_FILT);
  localparam logic signed [WW-1:0] K_NEG = -K_POS;
  localparam logic signed [WW-1:0] ONE   = WW'(1);

  logic signed [WW-1:0] walk;
  logic signed [WW-1:0] walk_step;
  logic signed [WW-1:0] walk_nxt;

  // Requests are combinational so the pending flags can latch them in the same edge cycle.
  always_comb begin
    walk_step = walk;
    add_req   = 1'b0;
    del_req   = 1'b0;
    if (phase_vld_i && (phase_i == PH_LEAD)) begin
      walk_step = walk + ONE;
    end else if (phase_vld_i && (phase_i == PH_LAG)) begin
      walk_step = walk - ONE;
    end
    walk_nxt = walk_step;
    if (walk_step == K_POS) begin
      del_req  = 1'b1;
      walk_nxt = '0;
    end else if (walk_step == K_NEG) begin
      add_req  = 1'b1;
      walk_nxt = '0;
    end
  end

  always_ff @(posedge clk32_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      walk <= '0;
    end else begin
      walk <= walk_nxt;
    end
  end

endmodule

// File: rtl/dpll_phase_adjust.sv
// rtl/dpll_phase_adjust.sv - DPLL core: data sync, pulse gate, divider, mid-bit sampler, pending corrections
module dpll_phase_adjust
  import dpll_pkg::*;
#(
  parameter int DIV_N  = DIV_N_DEF,
  parameter int DIV_W  = DIV_W_DEF,
  parameter int K_FILT = K_FILT_DEF
) (
  input  logic clk32_i,
  input  logic rst_n_i,
  input  logic clk_d1_i,
  input  logic clk_d2_i,
  input  logic data_i,
  output logic bitclk_o,
  output logic bit_o,
  output logic bit_vld_o,
  output logic lead_o,
  output logic lag_o
);

  localparam logic [DIV_W-1:0] CNT_MAX  = DIV_W'(DIV_N - 1);
  localparam logic [DIV_W-1:0] CNT_HALF = DIV_W'(DIV_N / 2);
  localparam logic [DIV_W-1:0] CNT_ONE  = DIV_W'(1);

  logic             data_s1;
  logic             data_s2;
  logic             data_dly;
  logic             edge_p;
  logic             del_pend;
  logic             add_pend;
  logic             del_use;
  logic             add_use;
  logic             gate_p;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_nxt;
  phase_e           phase;
  logic             add_req;
  logic             del_req;
  logic             del_left;
  logic             add_left;
  logic             del_pend_nxt;
  logic             add_pend_nxt;

  always_ff @(posedge clk32_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_s1  <= 1'b0;
      data_s2  <= 1'b0;
      data_dly <= 1'b0;
    end else begin
      data_s1  <= data_i;
      data_s2  <= data_s1;
      data_dly <= data_s2;
    end
  end

  assign edge_p = data_s2 ^ data_dly;

  // Deletion swallows a nominal pulse; insertion adds the staggered one.
  assign del_use = clk_d1_i & del_pend;
  assign add_use = clk_d2_i & add_pend;
  assign gate_p  = (clk_d1_i & ~del_pend) | add_use;
  assign div_nxt = (div_cnt == CNT_MAX) ? '0 : div_cnt + CNT_ONE;

  always_comb begin
    phase = PH_NONE;
    if (div_cnt != '0) begin
      phase = (div_cnt < CNT_HALF) ? PH_LEAD : PH_LAG;
    end
  end

  dpll_loop_filter #(
    .K_FILT (K_FILT)
  ) u_filter (
    .clk32_i     (clk32_i),
    .rst_n_i     (rst_n_i),
    .phase_i     (phase),
    .phase_vld_i (edge_p),
    .add_req     (add_req),
    .del_req     (del_req)
  );

  // Consumption is applied first, so a coinciding request sees the post-consumption flags.
  always_comb begin
    del_left     = del_pend & ~del_use;
    add_left     = add_pend & ~add_use;
    del_pend_nxt = del_left;
    add_pend_nxt = add_left;
    if (del_req) begin
      if (add_left) begin
        add_pend_nxt = 1'b0;
        del_pend_nxt = 1'b0;
      end else begin
        del_pend_nxt = 1'b1;
      end
    end else if (add_req) begin
      if (del_left) begin
        add_pend_nxt = 1'b0;
        del_pend_nxt = 1'b0;
      end else begin
        add_pend_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk32_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      del_pend <= 1'b0;
      add_pend <= 1'b0;
      lead_o   <= 1'b0;
      lag_o    <= 1'b0;
    end else begin
      del_pend <= del_pend_nxt;
      add_pend <= add_pend_nxt;
      lead_o   <= edge_p && (phase == PH_LEAD);
      lag_o    <= edge_p && (phase == PH_LAG);
    end
  end

  always_ff @(posedge clk32_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      div_cnt   <= '0;
      bitclk_o  <= 1'b0;
      bit_o     <= 1'b0;
      bit_vld_o <= 1'b0;
    end else begin
      bit_vld_o <= 1'b0;
      if (gate_p) begin
        div_cnt  <= div_nxt;
        bitclk_o <= (div_nxt < CNT_HALF);
        if (div_nxt == CNT_HALF) begin
          bit_o     <= data_s2;
          bit_vld_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dpll_phase_adjust.sv
// tb/tb_dpll_phase_adjust.sv - self-checking bench for dpll_phase_adjust
module tb_dpll_phase_adjust;

  logic clk = 1'b0;
  logic rst_n;
  logic clk_d1;
  logic clk_d2;
  logic data;
  logic bitclk;
  logic bit_q;
  logic bit_vld;
  logic lead;
  logic lag;

  dpll_phase_adjust dut (
    .clk32_i   (clk),
    .rst_n_i   (rst_n),
    .clk_d1_i  (clk_d1),
    .clk_d2_i  (clk_d2),
    .data_i    (data),
    .bitclk_o  (bitclk),
    .bit_o     (bit_q),
    .bit_vld_o (bit_vld),
    .lead_o    (lead),
    .lag_o     (lag)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    string name;
    int    k_even;
    int    k_odd;
    int    n_edges;
    int    exp_lead;
    int    exp_lag;
    int    exp_last_per;
    int    exp_walk;
    int    exp_hi;
    int    exp_lo;
  } vec_t;

  vec_t  vecs[$];
  int    exp_q[$];
  int    n_vec;
  int    n_bad;
  int    cyc;
  int    last_rise;
  int    lead_cnt;
  int    lag_cnt;
  int    vld_cnt;
  int    walk_hi;
  int    walk_lo;
  logic  mon_prev;
  string cur_name;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s/%s: got %0d, expected %0d", cur_name, name, act, exp);
    end
  endtask

  task automatic add_vec(input string name, input int ke, input int ko, input int n,
                         input int el, input int eg, input int ep, input int ew,
                         input int eh, input int elo);
    vec_t v;
    v.name = name; v.k_even = ke; v.k_odd = ko; v.n_edges = n;
    v.exp_lead = el; v.exp_lag = eg; v.exp_last_per = ep; v.exp_walk = ew;
    v.exp_hi = eh; v.exp_lo = elo;
    vecs.push_back(v);
  endtask

  // Nominal stream every 4th cycle, insertion stream 2 cycles later.
  initial begin
    int ph;
    ph = 0;
    clk_d1 = 1'b0;
    clk_d2 = 1'b0;
    forever begin
      @(negedge clk);
      ph = (ph + 1) % 4;
      clk_d1 = (ph == 0);
      clk_d2 = (ph == 2);
    end
  end

  // Scoreboard side: pops an expected period at every bitclk rise.
  initial begin
    cyc = 0; last_rise = 0; mon_prev = 1'b0;
    lead_cnt = 0; lag_cnt = 0; vld_cnt = 0; walk_hi = 0; walk_lo = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (lead) lead_cnt++;
      if (lag) lag_cnt++;
      if (bit_vld) vld_cnt++;
      if (int'(dut.u_filter.walk) > walk_hi) walk_hi = int'(dut.u_filter.walk);
      if (int'(dut.u_filter.walk) < walk_lo) walk_lo = int'(dut.u_filter.walk);
      if (bitclk && !mon_prev) begin
        if (exp_q.size() > 0) check("period", cyc - last_rise, exp_q.pop_front());
        last_rise = cyc;
      end
      mon_prev = bitclk;
    end
  end

  task automatic wait_rise();
    logic prev;
    prev = bitclk;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bitclk && !prev) return;
      prev = bitclk;
    end
    n_vec++;
    n_bad++;
    $display("FAIL %s/wait_rise: got no bitclk rise, expected one within 200 cycles", cur_name);
  endtask

  task automatic measure(output int per, output int hi, output int vld);
    logic prev;
    per = 0; hi = 0; vld = 0;
    prev = bitclk;
    for (int i = 0; i < 200; i++) begin
      if (bitclk) hi++;
      @(negedge clk);
      per++;
      if (bit_vld) vld++;
      if (bitclk && !prev) return;
      prev = bitclk;
    end
    n_vec++;
    n_bad++;
    $display("FAIL %s/measure: got no bitclk rise, expected one within 200 cycles", cur_name);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    data  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected end within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int per;
    int hi;
    int vld;
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    data  = 1'b0;
    cur_name = "reset";

    repeat (3) @(negedge clk);
    check("bitclk_rst", bitclk, 0);
    check("bit_rst", bit_q, 0);
    check("vld_rst", bit_vld, 0);
    check("lead_rst", lead, 0);
    check("lag_rst", lag, 0);

    // Run with data high so bit_o is 1, then reset asynchronously mid-cycle.
    rst_n = 1'b1;
    data  = 1'b1;
    wait_rise();
    wait_rise();
    check("bit_run", bit_q, 1);
    check("bitclk_run", bitclk, 1);
    #2 rst_n = 1'b0;
    #1;
    check("bitclk_async", bitclk, 0);
    check("bit_async", bit_q, 0);
    check("walk_async", int'(dut.u_filter.walk), 0);

    cur_name = "idle";
    @(negedge clk);
    data  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_rise();
    measure(per, hi, vld);
    check("first_partial", per, 60);
    for (int i = 0; i < 2; i++) begin
      measure(per, hi, vld);
      check("period", per, 64);
      check("high", hi, 32);
      check("vld_per_period", vld, 1);
    end

    add_vec("aligned", 16, 16, 4, 0, 0, 64, 0, 0, 0);
    add_vec("lead3", 4, 4, 3, 3, 0, 64, 3, 3, 0);
    add_vec("lead4", 4, 4, 4, 4, 0, 68, 0, 3, 0);
    add_vec("lag3", 12, 12, 3, 0, 3, 64, -3, 0, -3);
    add_vec("lag4", 12, 12, 4, 0, 4, 60, 0, 0, -3);
    add_vec("alt", 4, 12, 20, 10, 10, 64, 0, 1, 0);
    add_vec("lead_cnt1", 1, 1, 2, 2, 0, 64, 2, 2, 0);
    add_vec("lead_cnt7", 7, 7, 1, 1, 0, 64, 1, 1, 0);
    add_vec("lag_cnt8", 8, 8, 2, 0, 2, 64, -2, 0, -2);
    add_vec("lag_cnt15", 15, 15, 1, 0, 1, 64, -1, 0, -1);

    for (int v = 0; v < vecs.size(); v++) begin
      cur_name = vecs[v].name;
      do_reset();
      wait_rise();
      wait_rise();
      lead_cnt = 0; lag_cnt = 0; vld_cnt = 0; walk_hi = 0; walk_lo = 0;
      for (int e = 0; e < vecs[v].n_edges; e++) begin
        int k;
        k = (e % 2 == 0) ? vecs[v].k_even : vecs[v].k_odd;
        // Toggle so edge_p lands 2 cycles into the window where div_cnt == k.
        repeat (4 * k - 1) @(negedge clk);
        data = ~data;
        exp_q.push_back((e == vecs[v].n_edges - 1) ? vecs[v].exp_last_per : 64);
        wait_rise();
      end
      repeat (8) @(negedge clk);
      check("lead_pulses", lead_cnt, vecs[v].exp_lead);
      check("lag_pulses", lag_cnt, vecs[v].exp_lag);
      check("vld_pulses", vld_cnt, vecs[v].n_edges);
      check("walk_end", int'(dut.u_filter.walk), vecs[v].exp_walk);
      check("walk_max", walk_hi, vecs[v].exp_hi);
      check("walk_min", walk_lo, vecs[v].exp_lo);
      check("queue_drained", exp_q.size(), 0);
      exp_q.delete();
    end

    cur_name = "abort";
    do_reset();
    wait_rise();
    wait_rise();
    for (int e = 0; e < 4; e++) begin
      repeat (15) @(negedge clk);
      data = ~data;
      if (e < 3) wait_rise();
    end
    repeat (3) @(negedge clk);
    check("del_pend_set", dut.del_pend, 1);
    #2 rst_n = 1'b0;
    #1;
    check("del_pend_clr", dut.del_pend, 0);
    check("add_pend_clr", dut.add_pend, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_rise();
    measure(per, hi, vld);
    check("first_partial", per, 60);
    measure(per, hi, vld);
    check("first_period", per, 64);
    check("first_high", hi, 32);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
